// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared constants, FSM state encoding and helpers for the rr_mux8_arbiter slice.
// Optional build macro used by this slice: ARB_LOCK_EN (adds the lock input to the top).
package rr_mux8_arbiter_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
      return N_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 one-bit multiplexer shared by the eight serial producers.
module mux8 (
   input  logic [7:0] d,
   input  logic [2:0] sel,
   output logic       y
);

   assign y = d[sel];

endmodule

// File: rtl/rr_mux8_arbiter_pick8.sv
// Rotating priority pick: lowest index at or above ptr (wrapping 7->0) whose request is set.
module rr_pick8
   import rr_mux8_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any
);

   logic [SEL_W-1:0] cand;
   logic             found;

   always_comb begin
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = ptr + SEL_W'(k);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin owner of a shared 1-bit lane: bounded bursts, one dead cycle between owners.
// Build macro ARB_LOCK_EN adds a lock input that suspends the burst limit while granted.
module rr_mux8_arbiter
   import rr_mux8_arbiter_pkg::*;
#(
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
`ifdef ARB_LOCK_EN
   input  logic             lock,
`endif
   output logic [N_REQ-1:0] gnt,
   output logic [SEL_W-1:0] sel,
   output logic             dout,
   output logic             valid,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

   arb_state_e       state, state_n;
   logic [N_REQ-1:0] gnt_n;
   logic [SEL_W-1:0] sel_n;
   logic [SEL_W-1:0] ptr, ptr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             at_max;
   logic             limit_hit;

   rr_pick8 u_pick (
      .req (req),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   mux8 u_mux (
      .d   (din),
      .sel (sel),
      .y   (dout)
   );

   assign at_max = (cnt == CNT_MAX);

`ifdef ARB_LOCK_EN
   assign limit_hit = at_max && !lock;
`else
   assign limit_hit = at_max;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (pick_any) begin
               sel_n   = pick_idx;
               gnt_n   = onehot_sel(pick_idx);
               cnt_n   = '0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            // Saturating count keeps a locked burst parked at the limit.
            cnt_n = at_max ? cnt : cnt + CNT_W'(1);
            if (!req[sel] || limit_hit) begin
               gnt_n   = '0;
               ptr_n   = sel + SEL_W'(1);
               state_n = RELEASE;
            end
         end
         RELEASE: begin
            // Select may only move here or in IDLE, while valid is low.
            if (pick_any) begin
               sel_n   = pick_idx;
               gnt_n   = onehot_sel(pick_idx);
               cnt_n   = '0;
               state_n = GRANT;
            end else begin
               state_n = IDLE;
            end
         end
         default: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
      endcase
   end

   assign valid = (state == GRANT);
   assign busy  = (state != IDLE);

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Self-checking bench for rr_mux8_arbiter: BURST_LEN=4 main instance plus a BURST_LEN=1 instance.
module tb_rr_mux8_arbiter;

   logic       clk;
   logic       reset;
   logic [7:0] req, din, req1, din1;
   logic [7:0] gnt, gnt1;
   logic [2:0] sel, sel1;
   logic       dout, dout1, valid, valid1, busy, busy1;
`ifdef ARB_LOCK_EN
   logic       lock;
`endif

   // Observation vector: {busy, valid, gnt[7:0], sel[2:0]}
   logic [12:0] obs, obs1;
   logic [12:0] exp_q[$];
   int          n_checks;
   int          n_fail;

   assign obs  = {busy, valid, gnt, sel};
   assign obs1 = {busy1, valid1, gnt1, sel1};

   rr_mux8_arbiter #(.BURST_LEN(4), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .din   (din),
`ifdef ARB_LOCK_EN
      .lock  (lock),
`endif
      .gnt   (gnt),
      .sel   (sel),
      .dout  (dout),
      .valid (valid),
      .busy  (busy)
   );

   rr_mux8_arbiter #(.BURST_LEN(1), .CNT_W(3)) dut1 (
      .clk   (clk),
      .reset (reset),
      .req   (req1),
      .din   (din1),
`ifdef ARB_LOCK_EN
      .lock  (1'b0),
`endif
      .gnt   (gnt1),
      .sel   (sel1),
      .dout  (dout1),
      .valid (valid1),
      .busy  (busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      reset = 1'b1;
      req   = 8'h00;
      req1  = 8'h00;
      din   = 8'($urandom_range(0, 255));
      din1  = 8'($urandom_range(0, 255));
`ifdef ARB_LOCK_EN
      lock  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_exp(input logic b, input logic v, input logic [7:0] g, input logic [2:0] s);
      exp_q.push_back({b, v, g, s});
   endtask

   task automatic test_reset();
      logic [12:0] exp;
      apply_reset();
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected %h", obs, 13'h0);
      end
      n_checks++;
      if (obs1 !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_state_b1: got %h expected %h", obs1, 13'h0);
      end
      n_checks++;
      if (dout !== din[0]) begin
         n_fail++;
         $display("FAIL reset_dout: got %b expected %b", dout, din[0]);
      end
      reset = 1'b0;
      push_exp(1'b0, 1'b0, 8'h00, 3'd0);
      push_exp(1'b0, 1'b0, 8'h00, 3'd0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL idle_no_req cycle %0d: got %h expected %h", c, obs, exp);
         end
      end
   endtask

   task automatic test_single_requester();
      logic [12:0] exp;
      apply_reset();
      for (int g = 0; g < 2; g++) begin
         for (int c = 0; c < 4; c++) push_exp(1'b1, 1'b1, 8'h04, 3'd2);
         push_exp(1'b1, 1'b0, 8'h00, 3'd2);
      end
      req = 8'h04;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL single_req cycle %0d: got %h expected %h", c, obs, exp);
         end
         din = 8'($urandom_range(0, 255));
         din[2] = c[0];
         #1;
         if (exp[11]) begin
            n_checks++;
            if (dout !== din[2]) begin
               n_fail++;
               $display("FAIL single_dout cycle %0d: got %b expected %b", c, dout, din[2]);
            end
         end
      end
   endtask

   task automatic test_full_contention();
      logic [12:0] exp;
      logic [2:0]  o;
      apply_reset();
      for (int k = 0; k < 9; k++) begin
         o = 3'(k % 8);
         for (int c = 0; c < 4; c++) push_exp(1'b1, 1'b1, 8'(1) << o, o);
         push_exp(1'b1, 1'b0, 8'h00, o);
      end
      req = 8'hFF;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL full_contention cycle %0d: got %h expected %h", c, obs, exp);
         end
         n_checks++;
         if (!$onehot0(gnt)) begin
            n_fail++;
            $display("FAIL gnt_onehot cycle %0d: got %h expected one-hot or zero", c, gnt);
         end
         din = 8'($urandom_range(0, 255));
         #1;
         if (exp[11]) begin
            n_checks++;
            if (dout !== din[exp[2:0]]) begin
               n_fail++;
               $display("FAIL full_dout cycle %0d: got %b expected %b", c, dout, din[exp[2:0]]);
            end
         end
      end
   endtask

   task automatic test_early_drop();
      logic [12:0] exp;
      logic [7:0]  sched[8] = '{8'h60, 8'h60, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      apply_reset();
      push_exp(1'b1, 1'b1, 8'h20, 3'd5);
      push_exp(1'b1, 1'b1, 8'h20, 3'd5);
      push_exp(1'b1, 1'b0, 8'h00, 3'd5);
      push_exp(1'b1, 1'b1, 8'h40, 3'd6);
      push_exp(1'b1, 1'b0, 8'h00, 3'd6);
      push_exp(1'b0, 1'b0, 8'h00, 3'd6);
      push_exp(1'b0, 1'b0, 8'h00, 3'd6);
      req = sched[0];
      for (int c = 1; c < 8; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL early_drop cycle %0d: got %h expected %h", c, obs, exp);
         end
         req = sched[c];
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [12:0] exp;
      logic [7:0]  sched[5] = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h08};
      apply_reset();
      push_exp(1'b1, 1'b1, 8'h08, 3'd3);
      push_exp(1'b1, 1'b0, 8'h00, 3'd3);
      push_exp(1'b1, 1'b1, 8'h08, 3'd3);
      push_exp(1'b1, 1'b1, 8'h08, 3'd3);
      req = sched[0];
      for (int c = 1; c < 5; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL pre_reset cycle %0d: got %h expected %h", c, obs, exp);
         end
         req = sched[c];
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (obs !== 13'h0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs, 13'h0);
      end
      n_checks++;
      if (dout !== din[0]) begin
         n_fail++;
         $display("FAIL async_reset_dout: got %b expected %b", dout, din[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      // ptr back at 0 picks 3 from {3,4}; a stale ptr of 4 would pick 4
      req = 8'h18;
      push_exp(1'b1, 1'b1, 8'h08, 3'd3);
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL post_reset_ptr: got %h expected %h", obs, exp);
      end
   endtask

   task automatic test_burst_one();
      logic [12:0] exp;
      apply_reset();
      for (int k = 0; k < 2; k++) begin
         push_exp(1'b1, 1'b1, 8'h01, 3'd0);
         push_exp(1'b1, 1'b0, 8'h00, 3'd0);
         push_exp(1'b1, 1'b1, 8'h80, 3'd7);
         push_exp(1'b1, 1'b0, 8'h00, 3'd7);
      end
      req1 = 8'h81;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         n_checks++;
         if (obs1 !== exp) begin
            n_fail++;
            $display("FAIL burst_one cycle %0d: got %h expected %h", c, obs1, exp);
         end
      end
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      int waited;
      apply_reset();
      lock = 1'b1;
      req  = 8'h02;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if ({valid, gnt, sel} !== {1'b1, 8'h02, 3'd1}) begin
            n_fail++;
            $display("FAIL lock_hold cycle %0d: got %h expected %h", c, {valid, gnt, sel}, {1'b1, 8'h02, 3'd1});
         end
      end
      lock   = 1'b0;
      waited = 0;
      while (valid === 1'b1 && waited < 6) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (valid !== 1'b0 || waited > 4) begin
         n_fail++;
         $display("FAIL lock_release: got valid %b after %0d cycles expected 0 within 4", valid, waited);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_requester();
      test_full_contention();
      test_early_drop();
      test_reset_mid_burst();
      test_burst_one();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
